// File: rtl/midi_tx_adapter.sv
// -----------------------------------------------------------------------------
// midi_tx_adapter
//
// Serialises one MIDI message (status byte plus 0, 1 or 2 data bytes) onto a
// MIDI line. Each byte is framed as 1 start bit, 8 data bits LSB first and
// 1 stop bit. Bytes of one message follow each other with no idle gap.
// When RUN_STATUS is enabled, a channel-voice status byte that matches the
// last transmitted one is omitted. Data bytes always go out with bit 7 cleared.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   BAUD        MIDI line bit rate (bit period = CLK_HZ/BAUD clocks, >= 2)
//   RUN_STATUS  1 = running-status compression enabled
//
// Ports
//   sys_clk     in   system clock, all logic on the rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   MIDI_CMD    in   [7:0] status byte of the message to send
//   MIDI_DAT_0  in   [7:0] first data byte
//   MIDI_DAT_1  in   [7:0] second data byte
//   TX_START    in   one-cycle request strobe
//   MIDI_OUT    out  serial MIDI line, idle high, registered
//   TX_BUSY     out  high while a message is being sent
//   TX_DONE     out  one-cycle pulse when the last stop bit has completed
//   TX_ERR      out  one-cycle pulse when a request is rejected
//   fsm_state   out  [2:0] current transmit state, for debug/observation
//
// Request handshake:
//   TX_START is a single-cycle strobe with no ready signal. It is taken only
//   when the FSM is in IDLE and TX_DONE is low. A taken request whose
//   MIDI_CMD[7] is 1 latches all three input bytes and raises TX_BUSY (and
//   pulls MIDI_OUT low) in the next cycle. A taken request with MIDI_CMD[7]
//   clear produces a TX_ERR pulse in the next cycle and nothing else.
//   A strobe arriving while busy, or in the TX_DONE cycle, is dropped silently.
// -----------------------------------------------------------------------------
module midi_tx_adapter #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 31250,
    parameter int RUN_STATUS = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] MIDI_CMD,
    input  logic [7:0] MIDI_DAT_0,
    input  logic [7:0] MIDI_DAT_1,
    input  logic       TX_START,
    output logic       MIDI_OUT,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    output logic [2:0] fsm_state
);

    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

    // Last count of a full bit period.
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLKS - 1);
    // The stop bit is split: STOP_BIT covers counts 0..BIT_CLKS-2 and
    // NEXT_BYTE covers the final count, so the stop bit still lasts exactly
    // BIT_CLKS cycles while NEXT_BYTE gets a cycle to pick what follows.
    localparam logic [CW-1:0] STOP_LAST = CW'(BIT_CLKS - 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        NEXT_BYTE = 3'd4
    } state_t;

    // Index of the last byte of a message (0 = status only, 2 = status + 2 data).
    function automatic logic [1:0] last_index(input logic [7:0] status);
        logic [1:0] idx;
        idx = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: idx = 2'd2;
            4'hC, 4'hD:                   idx = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h2:       idx = 2'd2;
                    4'h1, 4'h3: idx = 2'd1;
                    default:    idx = 2'd0;
                endcase
            end
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [1:0]    idx_q,   idx_d;     // byte being sent: 0 status, 1 dat0, 2 dat1
    logic [1:0]    last_q;             // index of the final byte of this message
    logic [7:0]    cmd_q, dat0_q, dat1_q;
    logic [7:0]    rs_q;               // last transmitted channel status
    logic          rs_valid_q;
    logic          out_q,  out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q,  err_d;
    logic          load;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       take_req;
    logic       rs_hit;
    logic       baud_end;
    logic [2:0] bit_nxt;
    logic [7:0] cur_byte;

    assign take_req = (state_q == IDLE) && TX_START && !done_q;
    assign baud_end = (baud_q == BAUD_LAST);
    assign bit_nxt  = bit_q + 3'd1;

    // A status byte may be skipped only for channel-voice messages (0x80-0xEF).
    assign rs_hit = (RUN_STATUS != 0) && rs_valid_q &&
                    (MIDI_CMD == rs_q) && (MIDI_CMD[7:4] != 4'hF);

    always_comb begin
        cur_byte = cmd_q;
        case (idx_q)
            2'd1:    cur_byte = {1'b0, dat0_q[6:0]};
            2'd2:    cur_byte = {1'b0, dat1_q[6:0]};
            default: cur_byte = cmd_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and registered-output values
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                out_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = 3'd0;
                if (take_req) begin
                    if (MIDI_CMD[7]) begin
                        load    = 1'b1;
                        state_d = START_BIT;
                        out_d   = 1'b0;
                        busy_d  = 1'b1;
                        idx_d   = rs_hit ? 2'd1 : 2'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            START_BIT: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    out_d   = cur_byte[0];
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA_BITS: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        out_d   = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_nxt;
                        out_d = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP_BIT: begin
                baud_d = baud_q + 1'b1;
                if (baud_q == STOP_LAST) begin
                    state_d = NEXT_BYTE;
                end
            end

            NEXT_BYTE: begin
                // Final cycle of the stop bit: either chain the next byte
                // straight into its start bit or finish the message.
                baud_d = '0;
                bit_d  = 3'd0;
                if (idx_q == last_q) begin
                    state_d = IDLE;
                    out_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    out_d   = 1'b0;
                    state_d = START_BIT;
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 2'd0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Message latch and running-status register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_q      <= 8'h00;
            dat0_q     <= 8'h00;
            dat1_q     <= 8'h00;
            last_q     <= 2'd0;
            rs_q       <= 8'h00;
            rs_valid_q <= 1'b0;
        end else if (load) begin
            cmd_q  <= MIDI_CMD;
            dat0_q <= MIDI_DAT_0;
            dat1_q <= MIDI_DAT_1;
            last_q <= last_index(MIDI_CMD);
            if (MIDI_CMD[7:4] != 4'hF) begin
                rs_q       <= MIDI_CMD;
                rs_valid_q <= 1'b1;
            end else if (!MIDI_CMD[3]) begin
                // System common (0xF0-0xF7) cancels running status;
                // real-time (0xF8-0xFF) leaves it untouched.
                rs_valid_q <= 1'b0;
            end
        end
    end

    assign MIDI_OUT  = out_q;
    assign TX_BUSY   = busy_q;
    assign TX_DONE   = done_q;
    assign TX_ERR    = err_q;
    assign fsm_state = state_q;

endmodule

// File: doc/midi_tx_adapter.md
MIDI_TX_ADAPTER -- requirements
Module: midi_tx_adapter

Interface
REQ-001: Parameter CLK_HZ, default 48000000, system clock frequency in Hz.
REQ-002: Parameter BAUD, default 31250, MIDI line bit rate.
REQ-003: Parameter RUN_STATUS, default 0, 1 = running-status compression enabled.
REQ-004: sys_clk  input  1  single system clock, all logic on rising edge.
REQ-005: sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006: MIDI_CMD  input  8  status byte of packet to send.
REQ-007: MIDI_DAT_0  input  8  first data byte.
REQ-008: MIDI_DAT_1  input  8  second data byte.
REQ-009: TX_START  input  1  one-cycle request strobe, samples MIDI_CMD/DAT_0/DAT_1.
REQ-010: MIDI_OUT  output  1  serial MIDI line, idle high.
REQ-011: TX_BUSY  output  1  high while a packet is being sent.
REQ-012: TX_DONE  output  1  one-cycle pulse on packet completion.
REQ-013: TX_ERR  output  1  one-cycle pulse on a rejected request.

Function
REQ-014: The block SHALL use a bit period BIT_CLKS = CLK_HZ/BAUD (integer), i.e. 1536 cycles at the defaults.
REQ-015: Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1): 10*BIT_CLKS cycles per byte, with no idle gap between bytes of one packet.
REQ-016: The FSM SHALL have the states IDLE, START_BIT, DATA_BITS, STOP_BIT and NEXT_BYTE.
REQ-017: A TX_START in IDLE with MIDI_CMD[7]=1 SHALL latch all three input bytes, set TX_BUSY in the next cycle, and drive MIDI_OUT low in that same next cycle.
REQ-018: A TX_START in IDLE with MIDI_CMD[7]=0 SHALL pulse TX_ERR in the next cycle, send nothing, and leave TX_BUSY low.
REQ-019: A TX_START while TX_BUSY=1 SHALL be ignored: latched bytes unchanged, no TX_ERR.
REQ-020: Packet length SHALL be decoded from the latched status byte:
- 0x8n-0xBn, 0xEn, 0xF2: 3 bytes.
- 0xCn, 0xDn, 0xF1, 0xF3: 2 bytes.
- all other 0xFx: 1 byte.
REQ-021: Data bytes SHALL be sent with bit 7 forced to 0.
REQ-022: When RUN_STATUS=1 and the status is 0x80-0xEF and equal to the last transmitted channel status, the status byte SHALL be omitted and the first data byte SHALL start immediately (line low in the next cycle).
REQ-023: The running-status register SHALL be cleared by any 0xF0-0xF7 transmission and left unchanged by 0xF8-0xFF.
REQ-024: After the last stop bit completes, TX_DONE SHALL pulse for one cycle, TX_BUSY SHALL fall in that same cycle, and the FSM SHALL return to IDLE.
REQ-025: A TX_START in the same cycle as TX_DONE SHALL be ignored; it is accepted from the next cycle onward.
REQ-026: The bit counter (0-7) and the baud counter (0 to BIT_CLKS-1) SHALL wrap and reload with no off-by-one; every bit SHALL last exactly BIT_CLKS cycles.
REQ-027: MIDI_OUT SHALL be driven from a register (no combinational glitching).

Reset
REQ-028: While sys_rst_n=0, the block SHALL hold MIDI_OUT=1, TX_BUSY=0, TX_DONE=0 and TX_ERR=0, and the FSM SHALL be in IDLE.
REQ-029: Reset SHALL clear all counters and the running-status register.
REQ-030: Reset asserted mid-frame SHALL force MIDI_OUT high asynchronously and abort the packet, with no TX_DONE.
REQ-031: The first TX_START is accepted in the first cycle after sys_rst_n rises.

Verification
REQ-032: Note On: CMD=0x90, DAT_0=0x3C, DAT_1=0x64, RUN_STATUS=0 -> bytes 0x90, 0x3C, 0x64 on the line; TX_BUSY high for 46080 cycles; one TX_DONE pulse.
REQ-033: Program Change: CMD=0xC1, DAT_0=0x85 -> 2 bytes 0xC1, 0x05 in 30720 cycles.
REQ-034: Timing Clock: CMD=0xF8 -> 1 byte sent in 15360 cycles.
REQ-035: Running status: RUN_STATUS=1, two consecutive 0x90 Note On requests -> second packet sends only 2 bytes (30720 cycles).
- Then 0xF2 -> sent.
- Then 0x90 again -> status byte re-sent.
REQ-036: Rejected and ignored requests:
- CMD=0x45 -> TX_ERR pulse, MIDI_OUT stays 1.
- TX_START during busy -> ignored, in-flight bytes unchanged.
REQ-037: Reset mid-frame: sys_rst_n low at cycle 5000 of a packet -> MIDI_OUT=1 immediately; TX_BUSY=0; no TX_DONE; a new packet sends correctly after release.
